fifo_wr_arbiter: RTL

Round-robin write arbiter that shares one sync_fifo write port between NUM_REQ producers.
- Each producer presents a valid/ready stream.
- The arbiter locks one producer for a burst of up to MAX_BURST beats and drives the FIFO wr_en/din directly.
- The arbiter respects FIFO full, so no write is ever attempted into a full FIFO.
- The arbiter sits between the producer blocks and the sync_fifo write side.

---
 rtl/fifo_wr_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter feeding one sync_fifo write port from NUM_REQ valid/ready producers.
// A grant is locked for up to MAX_BURST beats; writes are never attempted while the FIFO is full.

module fifo_wr_arb_lane #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  sel,
  input  logic                  valid,
  input  logic                  full,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  ready,
  output logic                  xfer,
  output logic                  drop,
  output logic [DATA_WIDTH-1:0] dout
);
  assign ready = sel & ~full;
  assign xfer  = ready & valid;
  // owner lowering valid ends the burst even while the FIFO is full
  assign drop  = sel & ~valid;
  assign dout  = xfer ? data : '0;
endmodule

module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  parameter int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  output logic [ID_W-1:0]               fifo_wr_src,
  output logic                          busy,
  output logic [ID_W-1:0]               grant_id
);
  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [ID_W-1:0]  owner_q, owner_d;
  logic [ID_W-1:0]  last_winner_q, last_winner_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic [NUM_REQ-1:0]                 lane_sel, lane_xfer, lane_drop;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] lane_dout;
  logic                               xfer, drop;
  logic [DATA_WIDTH-1:0]              din_or;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
      assign lane_sel[gi] = (state_q == OWN) && (owner_q == ID_W'(gi));
      fifo_wr_arb_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
        .sel   (lane_sel[gi]),
        .valid (req_valid[gi]),
        .full  (fifo_full),
        .data  (req_data[gi*DATA_WIDTH +: DATA_WIDTH]),
        .ready (req_ready[gi]),
        .xfer  (lane_xfer[gi]),
        .drop  (lane_drop[gi]),
        .dout  (lane_dout[gi])
      );
    end
  endgenerate

  assign xfer = |lane_xfer;
  assign drop = |lane_drop;

  // non-owner lanes contribute zero, so an OR is the payload mux
  always_comb begin
    din_or = '0;
    for (int i = 0; i < NUM_REQ; i++) din_or = din_or | lane_dout[i];
  end

  assign fifo_wr_en  = xfer;
  assign fifo_din    = din_or;
  assign fifo_wr_src = xfer ? owner_q : '0;
  assign busy        = (state_q == OWN);
  assign grant_id    = (state_q == OWN) ? owner_q : '0;

  // cyclic search starting just after the previous winner
  logic            found;
  logic [ID_W-1:0] pick;
  logic [ID_W:0]   idx;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = {1'b0, last_winner_q} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(NUM_REQ)) idx = idx - (ID_W+1)'(NUM_REQ);
      if (!found && req_valid[idx[ID_W-1:0]]) begin
        found = 1'b1;
        pick  = idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_winner_d = last_winner_q;
    beat_cnt_d    = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d    = OWN;
          owner_d    = pick;
          beat_cnt_d = '0;
        end
      end
      OWN: begin
        if ((xfer && (beat_cnt_q == LAST_BEAT)) || (!xfer && drop)) begin
          state_d       = IDLE;
          last_winner_d = owner_q;
          beat_cnt_d    = '0;
        end else if (xfer) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      owner_q       <= '0;
      last_winner_q <= ID_W'(NUM_REQ - 1);
      beat_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_winner_q <= last_winner_d;
      beat_cnt_q    <= beat_cnt_d;
    end
  end
endmodule
